// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the seq_det_arbiter block.
package seq_det_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStream = 2'd1,
    StDone   = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned frame_len);
    return $clog2(frame_len + 1);
  endfunction

  function automatic int unsigned id_width(input int unsigned nreq);
    return $clog2(nreq);
  endfunction

  // Requester index examined at scan offset 'off' when 'last' owned the matcher last.
  function automatic int unsigned rr_index(input int unsigned last, input int unsigned off,
                                           input int unsigned n);
    return (last + 1 + off) % n;
  endfunction

endpackage

// File: rtl/seq_det_arbiter_matcher.sv
// Serial pattern matcher: latched pattern, shift window, fill count and registered match.
module seq_pattern_matcher
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_shift_en,
  input  logic             i_bit,
  input  logic [PAT_W-1:0] i_pattern,
  output logic             o_hit,
  output logic             o_match
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  r_pat;
  logic [PAT_W-1:0]  r_shift;
  logic [FILL_W-1:0] r_fill;
  logic              r_match;
  logic [PAT_W-1:0]  w_window;
  logic              w_full;

  assign w_window = {r_shift[PAT_W-2:0], i_bit};
  // Window holds PAT_W real bits once this shift lands.
  assign w_full   = (r_fill >= FILL_W'(PAT_W - 1));
  assign o_hit    = i_shift_en && w_full && (w_window == r_pat);
  assign o_match  = r_match;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat   <= '0;
      r_shift <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
    end else if (i_clr) begin
      r_pat   <= i_pattern;
      r_shift <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
    end else begin
      r_match <= o_hit;
      if (i_shift_en) begin
        r_shift <= w_window;
        if (r_fill != FILL_W'(PAT_W)) begin
          r_fill <= r_fill + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/seq_det_arbiter.sv
// Round-robin shared serial pattern matcher; optional stall timeout under SEQ_DET_ARB_TIMEOUT_EN.
module seq_det_arbiter
  import seq_det_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned PAT_W       = 6,
  parameter int unsigned FRAME_LEN   = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NREQ-1:0]                i_req,
  input  logic [NREQ-1:0]                i_bit_in,
  input  logic [NREQ-1:0]                i_bit_valid,
  input  logic [PAT_W-1:0]               i_pattern,
  output logic [NREQ-1:0]                o_gnt,
  output logic                           o_match,
  output logic [$clog2(FRAME_LEN+1)-1:0] o_match_cnt,
  output logic                           o_done,
  output logic [$clog2(NREQ)-1:0]        o_done_id,
  output logic                           o_aborted
);

  localparam int unsigned CNT_W = cnt_width(FRAME_LEN);
  localparam int unsigned ID_W  = id_width(NREQ);

  state_e          r_state;
  logic [NREQ-1:0] r_gnt;
  logic [ID_W-1:0] r_owner;
  logic [ID_W-1:0] r_last_owner;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] r_match_cnt;
  logic            r_done;
  logic [ID_W-1:0] r_done_id;
  logic            r_aborted;

  logic            w_win_vld;
  logic [ID_W-1:0] w_win_id;
  logic [ID_W-1:0] w_scan_idx;
  logic            w_own_req;
  logic            w_own_valid;
  logic            w_own_bit;
  logic            w_clr;
  logic            w_shift_en;
  logic            w_hit;
  logic            w_match;
  logic            w_timeout;

  // Scan from the requester after the last owner; the first set req wins.
  always_comb begin
    w_win_vld  = 1'b0;
    w_win_id   = '0;
    w_scan_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_scan_idx = ID_W'(rr_index(32'(r_last_owner), i, NREQ));
      if (!w_win_vld && i_req[w_scan_idx]) begin
        w_win_vld = 1'b1;
        w_win_id  = w_scan_idx;
      end
    end
  end

  assign w_own_req   = i_req[r_owner];
  assign w_own_valid = i_bit_valid[r_owner];
  assign w_own_bit   = i_bit_in[r_owner];
  assign w_clr       = (r_state == StIdle) && w_win_vld;
  assign w_shift_en  = (r_state == StStream) && w_own_req && w_own_valid;

`ifdef SEQ_DET_ARB_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT_CYC + 1);

  logic [STALL_W-1:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst || (r_state != StStream) || w_own_valid) begin
      r_stall_cnt <= '0;
    end else begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // Fires on the stall cycle that brings the run of empty cycles to TIMEOUT_CYC.
  assign w_timeout = (r_state == StStream) && !w_own_valid &&
                     (r_stall_cnt == STALL_W'(TIMEOUT_CYC - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYC == 0);
  assign w_timeout        = 1'b0;
`endif

  seq_pattern_matcher #(
    .PAT_W(PAT_W)
  ) u_matcher (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_clr),
    .i_shift_en(w_shift_en),
    .i_bit     (w_own_bit),
    .i_pattern (i_pattern),
    .o_hit     (w_hit),
    .o_match   (w_match)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_gnt        <= '0;
      r_owner      <= '0;
      r_last_owner <= ID_W'(NREQ - 1);
      r_bit_cnt    <= '0;
      r_match_cnt  <= '0;
      r_done       <= 1'b0;
      r_done_id    <= '0;
      r_aborted    <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_done    <= 1'b0;
          r_aborted <= 1'b0;
          if (w_win_vld) begin
            r_gnt       <= NREQ'(1) << w_win_id;
            r_owner     <= w_win_id;
            r_bit_cnt   <= '0;
            r_match_cnt <= '0;
            r_state     <= StStream;
          end
        end
        StStream: begin
          if (!w_own_req || w_timeout) begin
            r_state   <= StDone;
            r_gnt     <= '0;
            r_done    <= 1'b1;
            r_done_id <= r_owner;
            r_aborted <= 1'b1;
          end else if (w_own_valid) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_hit) begin
              r_match_cnt <= r_match_cnt + 1'b1;
            end
            if (r_bit_cnt == CNT_W'(FRAME_LEN - 1)) begin
              r_state   <= StDone;
              r_gnt     <= '0;
              r_done    <= 1'b1;
              r_done_id <= r_owner;
              r_aborted <= 1'b0;
            end
          end
        end
        StDone: begin
          r_done       <= 1'b0;
          r_aborted    <= 1'b0;
          r_last_owner <= r_owner;
          r_state      <= StIdle;
        end
        default: begin
          r_state <= StIdle;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  assign o_gnt       = r_gnt;
  assign o_match     = w_match;
  assign o_match_cnt = r_match_cnt;
  assign o_done      = r_done;
  assign o_done_id   = r_done_id;
  assign o_aborted   = r_aborted;

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Self-checking bench for seq_det_arbiter with a bit-list reference model.
module tb_seq_det_arbiter;

  localparam int unsigned NREQ        = 2;
  localparam int unsigned PAT_W       = 4;
  localparam int unsigned FRAME_LEN   = 8;
  localparam int unsigned TIMEOUT_CYC = 4;
  localparam int unsigned CNT_W       = $clog2(FRAME_LEN + 1);
  localparam int unsigned ID_W        = $clog2(NREQ);

  logic             clk;
  logic             rst;
  logic [NREQ-1:0]  i_req;
  logic [NREQ-1:0]  i_bit_in;
  logic [NREQ-1:0]  i_bit_valid;
  logic [PAT_W-1:0] i_pattern;
  logic [NREQ-1:0]  o_gnt;
  logic             o_match;
  logic [CNT_W-1:0] o_match_cnt;
  logic             o_done;
  logic [ID_W-1:0]  o_done_id;
  logic             o_aborted;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0]      obs_mask;
  int               obs_extra;
  int               obs_gnt_bad;
  int               obs_early_done;
  logic             obs_done;
  logic             obs_aborted;
  logic [ID_W-1:0]  obs_done_id;
  logic [CNT_W-1:0] obs_cnt;
  logic [NREQ-1:0]  obs_gnt_end;

  seq_det_arbiter #(
    .NREQ       (NREQ),
    .PAT_W      (PAT_W),
    .FRAME_LEN  (FRAME_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_bit_in   (i_bit_in),
    .i_bit_valid(i_bit_valid),
    .i_pattern  (i_pattern),
    .o_gnt      (o_gnt),
    .o_match    (o_match),
    .o_match_cnt(o_match_cnt),
    .o_done     (o_done),
    .o_done_id  (o_done_id),
    .o_aborted  (o_aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bit j of 'bits' is the j-th bit streamed; a match ends on bit j when the last PAT_W
  // streamed bits, oldest first, equal the pattern.
  function automatic logic [31:0] model_mask(input logic [31:0] bits, input int n,
                                             input logic [PAT_W-1:0] pat);
    logic [31:0]      m;
    logic [31:0]      sh;
    logic [PAT_W-1:0] w;
    m = '0;
    for (int j = PAT_W - 1; j < n; j++) begin
      sh = bits >> (j - int'(PAT_W) + 1);
      for (int k = 0; k < int'(PAT_W); k++) begin
        w[PAT_W-1-k] = sh[k];
      end
      if (w == pat) m = m | (32'(1) << j);
    end
    return m;
  endfunction

  task automatic set_lines(input logic [NREQ-1:0] own, input logic v, input logic b);
    logic [NREQ-1:0] rv;
    logic [NREQ-1:0] rb;
    rv = NREQ'($urandom);
    rb = NREQ'($urandom);
    i_bit_valid = (rv & ~own) | (v ? own : '0);
    i_bit_in    = (rb & ~own) | (b ? own : '0);
  endtask

  // Streams one frame for the owner while non-owner lines carry noise; records observations.
  task automatic drive_frame(input logic [NREQ-1:0] own, input int nbits,
                             input logic [31:0] bits, input int gap_mode,
                             input int drop_after, input int pat_change_at);
    logic [31:0] sh;
    obs_mask       = '0;
    obs_extra      = 0;
    obs_gnt_bad    = 0;
    obs_early_done = 0;
    for (int j = 0; j < nbits; j++) begin
      if (j == drop_after) break;
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(2) == 0)) begin
        set_lines(own, 1'b0, 1'($urandom));
        step();
        if (o_match === 1'b1) obs_extra++;
        if (o_gnt !== own) obs_gnt_bad++;
        if (o_done !== 1'b0) obs_early_done++;
      end
      sh = bits >> j;
      set_lines(own, 1'b1, sh[0]);
      if (j == pat_change_at) i_pattern = '0;
      step();
      if (o_match === 1'b1) obs_mask = obs_mask | (32'(1) << j);
      if (j < nbits - 1) begin
        if (o_gnt !== own) obs_gnt_bad++;
        if (o_done !== 1'b0) obs_early_done++;
      end
    end
    if (drop_after >= 0) begin
      i_req = i_req & ~own;
      set_lines(own, 1'b0, 1'b0);
      step();
    end
    obs_done    = o_done;
    obs_aborted = o_aborted;
    obs_done_id = o_done_id;
    obs_cnt     = o_match_cnt;
    obs_gnt_end = o_gnt;
    i_bit_valid = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_req = '0; i_bit_in = '0; i_bit_valid = '0; i_pattern = 4'b1011;
    step(); step();
    n_checks++; if (o_gnt !== '0) $display("FAIL reset_gnt: got %b want 0", o_gnt); else n_pass++;
    n_checks++; if (o_match !== 1'b0) $display("FAIL reset_match: got %b want 0", o_match); else n_pass++;
    n_checks++; if (o_done !== 1'b0) $display("FAIL reset_done: got %b want 0", o_done); else n_pass++;
    n_checks++; if (o_aborted !== 1'b0) $display("FAIL reset_aborted: got %b want 0", o_aborted); else n_pass++;
    n_checks++; if (o_match_cnt !== '0) $display("FAIL reset_cnt: got %0d want 0", o_match_cnt); else n_pass++;
    n_checks++; if (o_done_id !== '0) $display("FAIL reset_done_id: got %0d want 0", o_done_id); else n_pass++;
    rst = 1'b0;
    step();
    n_checks++; if (o_gnt !== '0) $display("FAIL idle_gnt: got %b want 0", o_gnt); else n_pass++;
  endtask

  task automatic test_single();
    logic [31:0] bits;
    logic [31:0] exp;
    bits = 32'b0110_1101;
    i_pattern = 4'b1011;
    exp = model_mask(bits, FRAME_LEN, 4'b1011);
    i_req = 2'b01;
    step();
    n_checks++; if (o_gnt !== 2'b01) $display("FAIL single_gnt: got %b want 01", o_gnt); else n_pass++;
    drive_frame(2'b01, FRAME_LEN, bits, 0, -1, -1);
    n_checks++; if (obs_mask !== exp) $display("FAIL single_mask: got %h want %h", obs_mask, exp); else n_pass++;
    n_checks++; if (obs_gnt_bad != 0 || obs_early_done != 0) $display("FAIL single_stream: gnt_bad %0d early_done %0d want 0", obs_gnt_bad, obs_early_done); else n_pass++;
    n_checks++; if (obs_done !== 1'b1) $display("FAIL single_done: got %b want 1", obs_done); else n_pass++;
    n_checks++; if (obs_done_id !== 1'b0) $display("FAIL single_done_id: got %0d want 0", obs_done_id); else n_pass++;
    n_checks++; if (obs_cnt !== CNT_W'($countones(exp))) $display("FAIL single_cnt: got %0d want %0d", obs_cnt, $countones(exp)); else n_pass++;
    n_checks++; if (obs_aborted !== 1'b0) $display("FAIL single_aborted: got %b want 0", obs_aborted); else n_pass++;
    n_checks++; if (obs_gnt_end !== '0) $display("FAIL single_gnt_done: got %b want 0", obs_gnt_end); else n_pass++;
    i_req = '0;
    step();
    n_checks++; if (o_done !== 1'b0) $display("FAIL single_done_pulse: got %b want 0", o_done); else n_pass++;
    n_checks++; if (o_match_cnt !== CNT_W'($countones(exp))) $display("FAIL single_cnt_hold: got %0d want %0d", o_match_cnt, $countones(exp)); else n_pass++;
  endtask

  task automatic test_contention();
    logic [31:0]     bits;
    logic [31:0]     exp;
    logic [NREQ-1:0] own;
    logic [NREQ-1:0] exp_own [3];
    exp_own[0] = 2'b01; exp_own[1] = 2'b10; exp_own[2] = 2'b01;
    rst = 1'b1; step(); rst = 1'b0;
    i_pattern = PAT_W'($urandom);
    i_req = 2'b11;
    step();
    for (int f = 0; f < 3; f++) begin
      own = exp_own[f];
      n_checks++; if (o_gnt !== own) $display("FAIL cont_gnt%0d: got %b want %b", f, o_gnt, own); else n_pass++;
      bits = $urandom;
      exp = model_mask(bits, FRAME_LEN, i_pattern);
      drive_frame(own, FRAME_LEN, bits, 0, -1, -1);
      n_checks++; if (obs_mask !== exp) $display("FAIL cont_mask%0d: got %h want %h", f, obs_mask, exp); else n_pass++;
      n_checks++; if (obs_gnt_bad != 0) $display("FAIL cont_onehot%0d: bad cycles %0d want 0", f, obs_gnt_bad); else n_pass++;
      n_checks++; if (obs_done !== 1'b1 || obs_done_id !== ID_W'(f % 2)) $display("FAIL cont_done%0d: got done %b id %0d want 1 id %0d", f, obs_done, obs_done_id, f % 2); else n_pass++;
      n_checks++; if (obs_cnt !== CNT_W'($countones(exp))) $display("FAIL cont_cnt%0d: got %0d want %0d", f, obs_cnt, $countones(exp)); else n_pass++;
      if (f == 2) i_req = '0;
      step();
      n_checks++; if (o_gnt !== '0) $display("FAIL cont_idle%0d: got %b want 0", f, o_gnt); else n_pass++;
      step();
    end
  endtask

  task automatic test_abort();
    logic [31:0] bits;
    bits = 32'b101;
    i_pattern = 4'b1011;
    i_req = 2'b10;
    step();
    n_checks++; if (o_gnt !== 2'b10) $display("FAIL abort_gnt: got %b want 10", o_gnt); else n_pass++;
    drive_frame(2'b10, FRAME_LEN, bits, 0, 3, -1);
    n_checks++; if (obs_done !== 1'b1) $display("FAIL abort_done: got %b want 1", obs_done); else n_pass++;
    n_checks++; if (obs_aborted !== 1'b1) $display("FAIL abort_flag: got %b want 1", obs_aborted); else n_pass++;
    n_checks++; if (obs_done_id !== 1'b1) $display("FAIL abort_done_id: got %0d want 1", obs_done_id); else n_pass++;
    n_checks++; if (obs_cnt !== '0) $display("FAIL abort_cnt: got %0d want 0", obs_cnt); else n_pass++;
    step();
    n_checks++; if (o_aborted !== 1'b0 || o_done !== 1'b0) $display("FAIL abort_clear: got done %b aborted %b want 0 0", o_done, o_aborted); else n_pass++;
  endtask

  task automatic test_gapped();
    logic [31:0]      bits;
    logic [31:0]      exp;
    logic [PAT_W-1:0] pat;
    int               gap;
    int               chg;
    for (int f = 0; f < 5; f++) begin
      if (f == 0) begin
        pat = 4'b1011; bits = 32'b0110_1101; gap = 1; chg = 3;
      end else begin
        pat = PAT_W'($urandom); bits = $urandom; gap = 2; chg = int'($urandom_range(7));
      end
      exp = model_mask(bits, FRAME_LEN, pat);
      i_pattern = pat;
      i_req = 2'b01;
      step();
      n_checks++; if (o_gnt !== 2'b01) $display("FAIL gap_gnt%0d: got %b want 01", f, o_gnt); else n_pass++;
      drive_frame(2'b01, FRAME_LEN, bits, gap, -1, chg);
      n_checks++; if (obs_mask !== exp) $display("FAIL gap_mask%0d: got %h want %h", f, obs_mask, exp); else n_pass++;
      n_checks++; if (obs_extra != 0 || obs_early_done != 0) $display("FAIL gap_idle%0d: extra %0d early %0d want 0", f, obs_extra, obs_early_done); else n_pass++;
      n_checks++; if (obs_done !== 1'b1 || obs_aborted !== 1'b0) $display("FAIL gap_done%0d: got done %b aborted %b want 1 0", f, obs_done, obs_aborted); else n_pass++;
      n_checks++; if (obs_cnt !== CNT_W'($countones(exp))) $display("FAIL gap_cnt%0d: got %0d want %0d", f, obs_cnt, $countones(exp)); else n_pass++;
      i_req = '0;
      step();
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] bits;
    bits = 4'b1101;
    i_pattern = 4'b1011;
    i_req = 2'b01;
    step();
    n_checks++; if (o_gnt !== 2'b01) $display("FAIL rstmid_gnt: got %b want 01", o_gnt); else n_pass++;
    for (int j = 0; j < 4; j++) begin
      set_lines(2'b01, 1'b1, bits[0]);
      bits = bits >> 1;
      step();
    end
    n_checks++; if (o_match_cnt !== CNT_W'(1)) $display("FAIL rstmid_precnt: got %0d want 1", o_match_cnt); else n_pass++;
    set_lines(2'b01, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    n_checks++; if (o_gnt !== '0) $display("FAIL rstmid_gnt0: got %b want 0", o_gnt); else n_pass++;
    n_checks++; if (o_match_cnt !== '0) $display("FAIL rstmid_cnt: got %0d want 0", o_match_cnt); else n_pass++;
    n_checks++; if (o_done !== 1'b0 || o_match !== 1'b0) $display("FAIL rstmid_done: got done %b match %b want 0 0", o_done, o_match); else n_pass++;
    rst = 1'b0;
    i_bit_valid = '0;
    i_req = 2'b11;
    step();
    n_checks++; if (o_gnt !== 2'b01) $display("FAIL rstmid_regrant: got %b want 01", o_gnt); else n_pass++;
    i_req = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

`ifdef SEQ_DET_ARB_TIMEOUT_EN
  task automatic test_timeout();
    i_pattern = 4'b1011;
    i_req = 2'b01;
    step();
    n_checks++; if (o_gnt !== 2'b01) $display("FAIL tmo_gnt: got %b want 01", o_gnt); else n_pass++;
    for (int j = 0; j < 2; j++) begin
      set_lines(2'b01, 1'b1, 1'b1);
      step();
    end
    for (int s = 1; s <= int'(TIMEOUT_CYC); s++) begin
      set_lines(2'b01, 1'b0, 1'($urandom));
      step();
      n_checks++; if (o_done !== (s == int'(TIMEOUT_CYC))) $display("FAIL tmo_done%0d: got %b want %b", s, o_done, s == int'(TIMEOUT_CYC)); else n_pass++;
    end
    n_checks++; if (o_aborted !== 1'b1) $display("FAIL tmo_aborted: got %b want 1", o_aborted); else n_pass++;
    i_req = '0;
    i_bit_valid = '0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_abort();
    test_gapped();
    test_reset_mid();
`ifdef SEQ_DET_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
